// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: sizes, operation encodings,
// commit classes and the per-entry payload.
package reorder_buffer_pkg;

  localparam int unsigned ROB_SIZE = 16;
  localparam int unsigned TAG_W    = 5;
  localparam int unsigned OPENUM_W = 6;
  localparam int unsigned IDX_W    = $clog2(ROB_SIZE);
  localparam int unsigned CNT_W    = IDX_W + 1;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_W    = 5;

  typedef logic [OPENUM_W-1:0] openum_t;

  localparam openum_t OP_NOP   = OPENUM_W'(0);
  localparam openum_t OP_LUI   = OPENUM_W'(1);
  localparam openum_t OP_AUIPC = OPENUM_W'(2);
  localparam openum_t OP_JAL   = OPENUM_W'(3);
  localparam openum_t OP_JALR  = OPENUM_W'(4);
  localparam openum_t OP_BEQ   = OPENUM_W'(5);
  localparam openum_t OP_BNE   = OPENUM_W'(6);
  localparam openum_t OP_BLT   = OPENUM_W'(7);
  localparam openum_t OP_BGE   = OPENUM_W'(8);
  localparam openum_t OP_BLTU  = OPENUM_W'(9);
  localparam openum_t OP_BGEU  = OPENUM_W'(10);
  localparam openum_t OP_LB    = OPENUM_W'(11);
  localparam openum_t OP_LH    = OPENUM_W'(12);
  localparam openum_t OP_LW    = OPENUM_W'(13);
  localparam openum_t OP_LBU   = OPENUM_W'(14);
  localparam openum_t OP_LHU   = OPENUM_W'(15);
  localparam openum_t OP_SB    = OPENUM_W'(16);
  localparam openum_t OP_SH    = OPENUM_W'(17);
  localparam openum_t OP_SW    = OPENUM_W'(18);
  localparam openum_t OP_ADDI  = OPENUM_W'(19);
  localparam openum_t OP_SLTI  = OPENUM_W'(20);
  localparam openum_t OP_SLTIU = OPENUM_W'(21);
  localparam openum_t OP_XORI  = OPENUM_W'(22);
  localparam openum_t OP_ORI   = OPENUM_W'(23);
  localparam openum_t OP_ANDI  = OPENUM_W'(24);
  localparam openum_t OP_SLLI  = OPENUM_W'(25);
  localparam openum_t OP_SRLI  = OPENUM_W'(26);
  localparam openum_t OP_SRAI  = OPENUM_W'(27);
  localparam openum_t OP_ADD   = OPENUM_W'(28);
  localparam openum_t OP_SUB   = OPENUM_W'(29);
  localparam openum_t OP_SLL   = OPENUM_W'(30);
  localparam openum_t OP_SLT   = OPENUM_W'(31);
  localparam openum_t OP_SLTU  = OPENUM_W'(32);
  localparam openum_t OP_XOR   = OPENUM_W'(33);
  localparam openum_t OP_SRL   = OPENUM_W'(34);
  localparam openum_t OP_SRA   = OPENUM_W'(35);
  localparam openum_t OP_OR    = OPENUM_W'(36);
  localparam openum_t OP_AND   = OPENUM_W'(37);

  typedef enum logic [1:0] {
    CLS_REG    = 2'd0,
    CLS_STORE  = 2'd1,
    CLS_BRANCH = 2'd2,
    CLS_JALR   = 2'd3
  } rob_class_e;

  typedef struct packed {
    logic              busy;
    logic              ready;
    rob_class_e        cls;
    logic [REG_W-1:0]  rd;
    logic [XLEN-1:0]   pc;
    logic              pred_jump;
    logic              jump;
    logic [XLEN-1:0]   val;
    logic [XLEN-1:0]   target;
  } rob_entry_t;

  // JAL resolves in the decoder, so it commits as a plain register write.
  function automatic rob_class_e rob_class_of(input openum_t op);
    rob_class_e cls;
    cls = CLS_REG;
    if (op == OP_JALR) begin
      cls = CLS_JALR;
    end else if (op >= OP_BEQ && op <= OP_BGEU) begin
      cls = CLS_BRANCH;
    end else if (op >= OP_SB && op <= OP_SW) begin
      cls = CLS_STORE;
    end
    return cls;
  endfunction

endpackage

// File: rtl/reorder_buffer_query.sv
// Operand query port: maps a wrapped tag to its entry's ready/value,
// with tag 0 meaning "no dependency".
module rob_query_port
  import reorder_buffer_pkg::*;
(
  input  logic [TAG_W-1:0]              tag_i,
  input  logic [ROB_SIZE-1:0]           live_i,
  input  logic [ROB_SIZE-1:0][XLEN-1:0] val_i,
  output logic                          ready_c_o,
  output logic [XLEN-1:0]               val_c_o
);

  logic [IDX_W-1:0] idx;

  assign idx = IDX_W'(tag_i - TAG_W'(1));

  always_comb begin
    ready_c_o = 1'b0;
    val_c_o   = '0;
    if (tag_i != '0) begin
      ready_c_o = live_i[idx];
      val_c_o   = val_i[idx];
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order writeback,
// in-order commit with mispredict rollback. Define ROB_BR_FEEDBACK_EN to add
// the branch-commit training outputs.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                issue_enable,
  input  logic [OPENUM_W-1:0] issue_openum,
  input  logic [REG_W-1:0]    issue_rd,
  input  logic [XLEN-1:0]     issue_pc,
  input  logic                issue_pred_jump,
  input  logic                issue_ready_inst,
  output logic [TAG_W-1:0]    next_rob_pos,
  output logic                rob_full,
  input  logic [TAG_W-1:0]    rob_rs1_pos,
  input  logic [TAG_W-1:0]    rob_rs2_pos,
  output logic                rob_rs1_ready,
  output logic                rob_rs2_ready,
  output logic [XLEN-1:0]     rob_rs1_val,
  output logic [XLEN-1:0]     rob_rs2_val,
  input  logic                alu_result_ready,
  input  logic [TAG_W-1:0]    alu_result_rob_pos,
  input  logic [XLEN-1:0]     alu_result_val,
  input  logic                alu_result_jump,
  input  logic [XLEN-1:0]     alu_result_pc,
  input  logic                lsb_load_result_ready,
  input  logic [TAG_W-1:0]    lsb_load_result_rob_pos,
  input  logic [XLEN-1:0]     lsb_load_result_val,
  output logic                commit_reg_enable,
  output logic [REG_W-1:0]    commit_rd,
  output logic [XLEN-1:0]     commit_val,
  output logic [TAG_W-1:0]    commit_rob_pos,
  output logic                commit_store_enable,
  output logic                rollback,
  output logic [XLEN-1:0]     rollback_pc
`ifdef ROB_BR_FEEDBACK_EN
  ,
  output logic                br_commit_enable,
  output logic [XLEN-1:0]     br_commit_pc,
  output logic                br_commit_taken
`endif
);

  rob_entry_t       entries_q [ROB_SIZE];
  rob_entry_t       entries_d [ROB_SIZE];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             commit_reg_enable_q, commit_reg_enable_d;
  logic [REG_W-1:0] commit_rd_q, commit_rd_d;
  logic [XLEN-1:0]  commit_val_q, commit_val_d;
  logic [TAG_W-1:0] commit_rob_pos_q, commit_rob_pos_d;
  logic             commit_store_enable_q, commit_store_enable_d;
  logic             rollback_q, rollback_d;
  logic [XLEN-1:0]  rollback_pc_q, rollback_pc_d;
`ifdef ROB_BR_FEEDBACK_EN
  logic             br_commit_enable_q, br_commit_enable_d;
  logic [XLEN-1:0]  br_commit_pc_q, br_commit_pc_d;
  logic             br_commit_taken_q, br_commit_taken_d;
`endif

  rob_entry_t                  head_e;
  logic                        do_issue;
  logic                        do_commit;
  logic                        mispredict;
  logic [IDX_W-1:0]            alu_idx;
  logic [IDX_W-1:0]            lsb_idx;
  logic                        alu_hit;
  logic                        lsb_hit;
  logic [ROB_SIZE-1:0]         live;
  logic [ROB_SIZE-1:0][XLEN-1:0] vals;

  assign head_e     = entries_q[head_q];
  assign do_issue   = issue_enable && !rollback_q && (count_q != CNT_W'(ROB_SIZE));
  assign do_commit  = !rollback_q && head_e.busy && head_e.ready;
  assign mispredict = do_commit && (head_e.cls == CLS_BRANCH || head_e.cls == CLS_JALR)
                      && (head_e.jump != head_e.pred_jump);

  assign alu_idx = IDX_W'(alu_result_rob_pos - TAG_W'(1));
  assign lsb_idx = IDX_W'(lsb_load_result_rob_pos - TAG_W'(1));
  assign alu_hit = alu_result_ready && !rollback_q && (alu_result_rob_pos != '0)
                   && entries_q[alu_idx].busy;
  assign lsb_hit = lsb_load_result_ready && !rollback_q && (lsb_load_result_rob_pos != '0)
                   && entries_q[lsb_idx].busy;

  // Full one entry early so a same-cycle decoder issue still has a slot.
  assign next_rob_pos = TAG_W'(tail_q) + TAG_W'(1);
  assign rob_full     = count_q >= CNT_W'(ROB_SIZE - 1);

  always_comb begin
    live = '0;
    vals = '0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      live[i] = entries_q[i].busy && entries_q[i].ready;
      vals[i] = entries_q[i].val;
    end
  end

  rob_query_port u_query_rs1 (
    .tag_i     (rob_rs1_pos),
    .live_i    (live),
    .val_i     (vals),
    .ready_c_o (rob_rs1_ready),
    .val_c_o   (rob_rs1_val)
  );

  rob_query_port u_query_rs2 (
    .tag_i     (rob_rs2_pos),
    .live_i    (live),
    .val_i     (vals),
    .ready_c_o (rob_rs2_ready),
    .val_c_o   (rob_rs2_val)
  );

  always_comb begin
    entries_d             = entries_q;
    head_d                = head_q;
    tail_d                = tail_q;
    count_d               = count_q;
    commit_reg_enable_d   = 1'b0;
    commit_store_enable_d = 1'b0;
    rollback_d            = 1'b0;
    commit_rd_d           = commit_rd_q;
    commit_val_d          = commit_val_q;
    commit_rob_pos_d      = commit_rob_pos_q;
    rollback_pc_d         = rollback_pc_q;
`ifdef ROB_BR_FEEDBACK_EN
    br_commit_enable_d    = 1'b0;
    br_commit_pc_d        = br_commit_pc_q;
    br_commit_taken_d     = br_commit_taken_q;
`endif

    if (alu_hit) begin
      entries_d[alu_idx].ready  = 1'b1;
      entries_d[alu_idx].val    = alu_result_val;
      entries_d[alu_idx].jump   = alu_result_jump;
      entries_d[alu_idx].target = alu_result_pc;
    end
    if (lsb_hit) begin
      entries_d[lsb_idx].ready = 1'b1;
      entries_d[lsb_idx].val   = lsb_load_result_val;
    end

    if (do_issue) begin
      entries_d[tail_q].busy      = 1'b1;
      entries_d[tail_q].ready     = issue_ready_inst;
      entries_d[tail_q].cls       = rob_class_of(issue_openum);
      entries_d[tail_q].rd        = issue_rd;
      entries_d[tail_q].pc        = issue_pc;
      entries_d[tail_q].pred_jump = issue_pred_jump;
      entries_d[tail_q].jump      = 1'b0;
      entries_d[tail_q].val       = '0;
      entries_d[tail_q].target    = '0;
      tail_d                      = tail_q + IDX_W'(1);
    end

    if (do_commit) begin
      entries_d[head_q].busy = 1'b0;
      head_d                 = head_q + IDX_W'(1);
      commit_rd_d            = head_e.rd;
      commit_val_d           = head_e.val;
      commit_rob_pos_d       = TAG_W'(head_q) + TAG_W'(1);
      commit_reg_enable_d    = (head_e.cls == CLS_REG) || (head_e.cls == CLS_JALR);
      commit_store_enable_d  = (head_e.cls == CLS_STORE);
`ifdef ROB_BR_FEEDBACK_EN
      br_commit_enable_d     = (head_e.cls == CLS_BRANCH);
      br_commit_pc_d         = head_e.pc;
      br_commit_taken_d      = head_e.jump;
`endif
    end

    count_d = count_q + CNT_W'(do_issue) - CNT_W'(do_commit);

    // A mispredict squashes everything younger, including this cycle's issue.
    if (mispredict) begin
      rollback_d    = 1'b1;
      rollback_pc_d = head_e.jump ? head_e.target : head_e.pc + XLEN'(4);
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries_d[i].busy = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries_q[i] <= '0;
      end
      head_q                <= '0;
      tail_q                <= '0;
      count_q               <= '0;
      commit_reg_enable_q   <= 1'b0;
      commit_rd_q           <= '0;
      commit_val_q          <= '0;
      commit_rob_pos_q      <= '0;
      commit_store_enable_q <= 1'b0;
      rollback_q            <= 1'b0;
      rollback_pc_q         <= '0;
`ifdef ROB_BR_FEEDBACK_EN
      br_commit_enable_q    <= 1'b0;
      br_commit_pc_q        <= '0;
      br_commit_taken_q     <= 1'b0;
`endif
    end else if (rdy) begin
      entries_q             <= entries_d;
      head_q                <= head_d;
      tail_q                <= tail_d;
      count_q               <= count_d;
      commit_reg_enable_q   <= commit_reg_enable_d;
      commit_rd_q           <= commit_rd_d;
      commit_val_q          <= commit_val_d;
      commit_rob_pos_q      <= commit_rob_pos_d;
      commit_store_enable_q <= commit_store_enable_d;
      rollback_q            <= rollback_d;
      rollback_pc_q         <= rollback_pc_d;
`ifdef ROB_BR_FEEDBACK_EN
      br_commit_enable_q    <= br_commit_enable_d;
      br_commit_pc_q        <= br_commit_pc_d;
      br_commit_taken_q     <= br_commit_taken_d;
`endif
    end
  end

  assign commit_reg_enable   = commit_reg_enable_q;
  assign commit_rd           = commit_rd_q;
  assign commit_val          = commit_val_q;
  assign commit_rob_pos      = commit_rob_pos_q;
  assign commit_store_enable = commit_store_enable_q;
  assign rollback            = rollback_q;
  assign rollback_pc         = rollback_pc_q;
`ifdef ROB_BR_FEEDBACK_EN
  assign br_commit_enable    = br_commit_enable_q;
  assign br_commit_pc        = br_commit_pc_q;
  assign br_commit_taken     = br_commit_taken_q;
`endif

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular reorder buffer for the Tomasulo core, at the far end of the decoder's issue/query protocol.
- Allocates the entry named by next_rob_pos on each issue and answers the decoder's rs1/rs2 tag queries.
- Collects ALU and LSB results, then commits in program order to the regfile and LSB.
- Detects branch mispredicts at commit and drives the global rollback.

Parameters:
ROB_SIZE, 16, number of entries (power of two)
TAG_W, 5, wrapped tag width; tag 0 = "no dependency", tags 1..ROB_SIZE map to entry tag-1
OPENUM_W, 6, width of the operation enumeration

Ports:
clk  in  1  clock
rst  in  1  reset
rdy  in  1  global enable; low freezes all state
issue_enable  in  1  decoder issues one instruction this cycle
issue_openum  in  OPENUM_W  operation; classified as REG / STORE / BRANCH / JALR
issue_rd  in  5  destination register (0 for store/branch)
issue_pc  in  32  instruction pc
issue_pred_jump  in  1  fetch predicted taken
issue_ready_inst  in  1  entry is ready at issue (stores)
next_rob_pos  out  TAG_W  tag the next issue receives
rob_full  out  1  fetch must stall
rob_rs1_pos / rob_rs2_pos  in  TAG_W  query tags
rob_rs1_ready / rob_rs2_ready  out  1  queried entry has its value
rob_rs1_val / rob_rs2_val  out  32  queried value
alu_result_ready  in  1  ALU writeback valid
alu_result_rob_pos  in  TAG_W  ALU writeback tag
alu_result_val  in  32  ALU result (pc+4 for JAL/JALR)
alu_result_jump  in  1  actual taken outcome
alu_result_pc  in  32  actual target
lsb_load_result_ready  in  1  load writeback valid
lsb_load_result_rob_pos  in  TAG_W  load writeback tag
lsb_load_result_val  in  32  load data
commit_reg_enable  out  1  regfile write pulse
commit_rd  out  5  committed destination
commit_val  out  32  committed value
commit_rob_pos  out  TAG_W  committed tag; regfile clears its dependency if it matches
commit_store_enable  out  1  LSB may perform the store with tag commit_rob_pos
rollback  out  1  flush pulse to all units
rollback_pc  out  32  refetch address

Behaviour:
- Reset: rst is synchronous, active-high. head=tail=count=0; all entries not busy; every registered output = 0.
- rdy low: no state or output changes.
- next_rob_pos = tail+1 (combinational).
- rob_full = (count >= ROB_SIZE-1), combinational; this gives one cycle of slack for the decoder's same-cycle issue.
- Issue (rdy, issue_enable, !rollback): entry[tail] gets busy=1, ready=issue_ready_inst, rd, pc, pred_jump, class. tail wraps ROB_SIZE-1 -> 0.
- Issue while count==ROB_SIZE is dropped; the bench flags it as an error.
- Writeback: a valid ALU or LSB result sets the entry's ready, val, jump and target.
  - Both writeback ports may fire in the same cycle for different tags.
  - A writeback to a non-busy entry is ignored.
- Query: ready = busy && ready bit; val = entry val. Tag 0 returns ready=0, val=0. Combinational.
- Commit: at most one per cycle, when entry[head] is busy && ready. Outputs are registered one-cycle pulses.
  - REG / JALR class: commit_reg_enable=1.
  - STORE class: commit_store_enable=1.
  - BRANCH class: neither enable.
  - Then head++ and the entry is freed.
- Same-cycle issue and commit: count unchanged.
- Mispredict: committing a BRANCH/JALR with jump != pred_jump sets rollback=1 for exactly one cycle.
  - rollback_pc = jump ? target : pc+4.
  - At that same edge: all busy cleared, head=tail=count=0.
  - JALR always has pred_jump=0, so it always rolls back; it still writes rd.
- While rollback=1: issue and writebacks are ignored, no commit.

Optional Feature:
ROB_BR_FEEDBACK_EN
- Defined: adds outputs br_commit_enable (1), br_commit_pc (32), br_commit_taken (1), registered. It pulses on every BRANCH commit, mispredicted or not, for predictor training.
- Undefined: these ports do not exist; no added logic.

Decomposition:
- Shared package (definition header): TAG_W, ROB_SIZE, OPENUM encodings, ROB class constants (REG/STORE/BRANCH/JALR), and a class-from-openum function.
- One sub-module, rob_query_port (tag -> ready/val mux plus tag-0 check), instantiated twice.

Test Plan:
- Issue add (rd=5, tag 1), ALU writeback tag 1 val 0x2A -> next cycle commit_reg_enable=1, commit_rd=5, commit_val=0x2A, commit_rob_pos=1.
- Issue 15 entries -> rob_full=1; commit one -> rob_full=0; issue 18 total with interleaved commits -> tail wraps, next_rob_pos returns to 1.
- Store issued with issue_ready_inst=1 behind an unready load -> no commit until load writeback; then load commits, next cycle commit_store_enable=1.
- Branch pc=0x100 pred_jump=0, ALU jump=1 target 0x200 -> rollback=1 one cycle, rollback_pc=0x200, count=0, younger writebacks ignored.
- Query tag 3 before and after its writeback val 7 -> ready 0 then ready 1 val 7; query tag 0 -> ready 0; same-cycle ALU+LSB writebacks to tags 2 and 3 both land.
- rst asserted mid-stream with 6 entries busy -> next cycle all outputs 0, next_rob_pos=1.
